// File: rtl/accel_pkg.sv
// Shared types for the accelerator message buffer: FSM states, error codes
// and the error-priority helper.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FEED    = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } acc_state_t;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_LEN  = 3'd1,
        ERR_ADDR = 3'd2,
        ERR_BUSY = 3'd3,
        ERR_OVF  = 3'd4
    } acc_error_t;

    // Pick the single error to record when several are raised in one cycle.
    // Overflow outranks length, which outranks busy, which outranks address.
    function automatic acc_error_t err_pick(input logic ovf, input logic len,
                                            input logic busy, input logic addr);
        acc_error_t e;
        if (ovf) begin
            e = ERR_OVF;
        end else if (len) begin
            e = ERR_LEN;
        end else if (busy) begin
            e = ERR_BUSY;
        end else if (addr) begin
            e = ERR_ADDR;
        end else begin
            e = ERR_NONE;
        end
        return e;
    endfunction

endpackage

// File: rtl/accel_buf_regfile.sv
// Flop-based word buffer with one byte-enabled write port and one
// combinational read port. Contents are cleared by synchronous reset.
module accel_buf_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [BW-1:0]         be,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Clear on reset, otherwise merge the enabled bytes of the write word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && (int'(waddr) < DEPTH)) begin
            for (int b = 0; b < BW; b++) begin
                if (be[b]) begin
                    mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Combinational read; indices past the last entry read as zero
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/accel_msg_buffer.sv
// Message buffer and job controller between the host memory port and an
// accelerator core: host fills the input buffer, a job streams it to the
// core, the results land in the output buffer for the host to read back.
module accel_msg_buffer
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int IN_DEPTH   = 42,
    parameter int OUT_DEPTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          mem_en,
    input  logic [ADDR_WIDTH-1:0]                         mem_addr,
    input  logic                                          mem_we,
    input  logic [DATA_WIDTH/8-1:0]                       mem_be,
    input  logic [DATA_WIDTH-1:0]                         mem_wdata,
    output logic [DATA_WIDTH-1:0]                         mem_rdata,
    input  logic                                          start,
    input  logic [$clog2(IN_DEPTH+1)-1:0]                 in_len,
    output logic                                          done,
    output logic [$clog2(OUT_DEPTH*DATA_WIDTH/8+1)-1:0]   output_length_byte,
    output acc_state_t                                    accel_state,
    output acc_error_t                                    accel_error,
    output logic                                          core_in_valid,
    output logic [DATA_WIDTH-1:0]                         core_in_data,
    output logic                                          core_in_last,
    input  logic                                          core_in_ready,
    input  logic                                          core_out_valid,
    input  logic [DATA_WIDTH-1:0]                         core_out_data,
    input  logic                                          core_out_last,
    output logic                                          core_out_ready
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LEN_W  = $clog2(IN_DEPTH + 1);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int OLB_W  = $clog2(OUT_DEPTH * DATA_WIDTH / 8 + 1);
    localparam int IN_AW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    acc_state_t             state_r;
    acc_error_t             err_r;
    logic [LEN_W-1:0]       rd_ptr_r;
    logic [LEN_W-1:0]       len_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   done_r;
    logic [OLB_W-1:0]       olb_r;
    logic [DATA_WIDTH-1:0]  rdata_r;

    logic                   feed_s;
    logic                   collect_s;
    logic                   busy_s;
    logic                   in_hit_s;
    logic                   out_hit_s;
    logic [IN_AW-1:0]       host_in_idx_s;
    logic [OUT_AW-1:0]      host_out_idx_s;
    logic                   len_ok_s;
    logic                   start_ok_s;
    logic                   in_hs_s;
    logic                   out_hs_s;
    logic                   in_last_s;
    logic                   out_room_s;
    logic                   in_we_s;
    logic                   out_we_s;
    logic [IN_AW-1:0]       in_raddr_s;
    logic [DATA_WIDTH-1:0]  in_rdata_s;
    logic [DATA_WIDTH-1:0]  out_rdata_s;
    logic [DATA_WIDTH-1:0]  host_rd_s;
    logic [CNT_W-1:0]       cnt_final_s;
    logic                   addr_err_s;
    acc_error_t             err_set_s;

    // Address decode, handshakes and per-cycle error detection
    always_comb begin
        feed_s         = (state_r == FEED);
        collect_s      = (state_r == COLLECT);
        busy_s         = feed_s || collect_s;
        in_hit_s       = (mem_addr < ADDR_WIDTH'(IN_DEPTH));
        out_hit_s      = !in_hit_s && (mem_addr < ADDR_WIDTH'(IN_DEPTH + OUT_DEPTH));
        host_in_idx_s  = IN_AW'(mem_addr);
        host_out_idx_s = OUT_AW'(mem_addr - ADDR_WIDTH'(IN_DEPTH));
        len_ok_s       = (in_len != '0) && (in_len <= LEN_W'(IN_DEPTH));
        start_ok_s     = start && !busy_s && len_ok_s;
        in_hs_s        = feed_s && core_in_ready;
        out_hs_s       = collect_s && core_out_valid;
        in_last_s      = feed_s && (rd_ptr_r == (len_r - LEN_W'(1)));
        out_room_s     = (cnt_r < CNT_W'(OUT_DEPTH));
        in_we_s        = mem_en && mem_we && !busy_s && in_hit_s;
        out_we_s       = out_hs_s && out_room_s;
        cnt_final_s    = out_room_s ? (cnt_r + CNT_W'(1)) : cnt_r;
        // The core owns the input buffer read port while a message streams out
        if (feed_s) begin
            in_raddr_s = IN_AW'(rd_ptr_r);
        end else begin
            in_raddr_s = host_in_idx_s;
        end
        if (in_hit_s) begin
            host_rd_s = in_rdata_s;
        end else if (out_hit_s) begin
            host_rd_s = out_rdata_s;
        end else begin
            host_rd_s = '0;
        end
        // Writes are only legal into the input region; reads into either buffer
        if (mem_en && !busy_s) begin
            if (mem_we) begin
                addr_err_s = !in_hit_s;
            end else begin
                addr_err_s = !(in_hit_s || out_hit_s);
            end
        end else begin
            addr_err_s = 1'b0;
        end
        err_set_s = err_pick(out_hs_s && !out_room_s,
                             start && !busy_s && !len_ok_s,
                             busy_s && (start || mem_en),
                             addr_err_s);
    end

    accel_buf_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IN_DEPTH)
    ) u_in_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (in_we_s),
        .waddr (host_in_idx_s),
        .be    (mem_be),
        .wdata (mem_wdata),
        .raddr (in_raddr_s),
        .rdata (in_rdata_s)
    );

    accel_buf_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH)
    ) u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (out_we_s),
        .waddr (OUT_AW'(cnt_r)),
        .be    ({BYTES{1'b1}}),
        .wdata (core_out_data),
        .raddr (host_out_idx_s),
        .rdata (out_rdata_s)
    );

    // Job FSM with its pointers, result counter and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rd_ptr_r <= '0;
            len_r    <= '0;
            cnt_r    <= '0;
            done_r   <= 1'b0;
            olb_r    <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        state_r  <= FEED;
                        rd_ptr_r <= '0;
                        len_r    <= in_len;
                        cnt_r    <= '0;
                        done_r   <= 1'b0;
                        olb_r    <= '0;
                    end
                end
                FEED: begin
                    if (in_hs_s) begin
                        rd_ptr_r <= rd_ptr_r + LEN_W'(1);
                        if (in_last_s) begin
                            state_r <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (out_hs_s) begin
                        cnt_r <= cnt_final_s;
                        if (core_out_last) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            olb_r   <= OLB_W'(cnt_final_s) * OLB_W'(BYTES);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky error code: latest raised error wins, an accepted start clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= ERR_NONE;
        end else if (err_set_s != ERR_NONE) begin
            err_r <= err_set_s;
        end else if (start_ok_s) begin
            err_r <= ERR_NONE;
        end
    end

    // Registered host read data; busy-time accesses return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (mem_en && busy_s) begin
            rdata_r <= '0;
        end else if (mem_en && !mem_we) begin
            rdata_r <= host_rd_s;
        end
    end

    assign mem_rdata          = rdata_r;
    assign done               = done_r;
    assign output_length_byte = olb_r;
    assign accel_state        = state_r;
    assign accel_error        = err_r;
    assign core_in_valid      = feed_s;
    assign core_in_data       = feed_s ? in_rdata_s : '0;
    assign core_in_last       = in_last_s;
    assign core_out_ready     = collect_s;

endmodule

// File: tb/tb_accel_msg_buffer.sv
// Self-checking bench for accel_msg_buffer: host-port vector table, a stream
// scoreboard for the core-facing message, and multi-cycle job sequences.
module tb_accel_msg_buffer;
    import accel_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_be = 4'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        start = 1'b0;
    logic [5:0]  in_len = 6'd0;
    logic        done;
    logic [6:0]  output_length_byte;
    acc_state_t  accel_state;
    acc_error_t  accel_error;
    logic        core_in_valid;
    logic [31:0] core_in_data;
    logic        core_in_last;
    logic        core_in_ready = 1'b0;
    logic        core_out_valid = 1'b0;
    logic [31:0] core_out_data = 32'd0;
    logic        core_out_last = 1'b0;
    logic        core_out_ready;

    accel_msg_buffer dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .start(start),
        .in_len(in_len), .done(done), .output_length_byte(output_length_byte),
        .accel_state(accel_state), .accel_error(accel_error),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_in_last(core_in_last), .core_in_ready(core_in_ready),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .core_out_last(core_out_last), .core_out_ready(core_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        bit          we;
        int unsigned addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        acc_error_t  exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          in_hs_cnt = 0;
    beat_t       exp_in_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] in_model [42];
    vec_t        vecs [15];
    bit          stall_pend = 1'b0;
    logic [31:0] stall_data = 32'd0;
    logic        stall_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got timeout expected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int unsigned addr, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'(addr);
        tick();
        mem_en = 1'b0;
        check(name, mem_rdata, rd_q.pop_front());
    endtask

    task automatic push_stream(input int len);
        for (int i = 0; i < len; i++) begin
            exp_in_q.push_back('{in_model[i], (i == len - 1)});
        end
    endtask

    task automatic start_job(input logic [5:0] len);
        in_hs_cnt = 0;
        start = 1'b1; in_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_collect(input bit random_ready);
        for (int i = 0; i < 400 && accel_state != COLLECT; i++) begin
            if (random_ready) core_in_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if (accel_state != COLLECT) timeout_fail("wait_collect");
        core_in_ready = 1'b0;
    endtask

    task automatic send_results(input int n, input logic [31:0] base);
        bit acc;
        for (int i = 0; i < n; i++) begin
            core_out_valid = 1'b1;
            core_out_data  = base + 32'(i);
            core_out_last  = (i == n - 1);
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                acc = core_out_ready;
                tick();
            end
            if (!acc) begin
                timeout_fail("send_results");
                break;
            end
        end
        core_out_valid = 1'b0;
        core_out_last  = 1'b0;
    endtask

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Stream scoreboard on the core input side plus stall stability check
    always @(posedge clk) begin
        if (!rst && core_in_valid) begin
            if (stall_pend) begin
                check("stall_data", core_in_data, stall_data);
                check("stall_last", core_in_last, stall_last);
            end
            if (core_in_ready) begin
                if (exp_in_q.size() == 0) begin
                    check("in_unexpected", 1'b1, 1'b0);
                end else begin
                    beat_t e;
                    e = exp_in_q.pop_front();
                    check("in_data", core_in_data, e.data);
                    check("in_last", core_in_last, e.last);
                end
                in_hs_cnt++;
                stall_pend = 1'b0;
            end else begin
                stall_pend = 1'b1;
                stall_data = core_in_data;
                stall_last = core_in_last;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    initial begin
        int t0;
        for (int i = 0; i < 42; i++) in_model[i] = 32'd0;
        vecs[0]  = '{1'b1, 3,  4'b0101, 32'hFFFF_FFFF, 32'h0,         ERR_NONE};
        vecs[1]  = '{1'b0, 3,  4'b0000, 32'h0,         32'h00FF_00FF, ERR_NONE};
        vecs[2]  = '{1'b1, 3,  4'b1010, 32'hAABB_CCDD, 32'h0,         ERR_NONE};
        vecs[3]  = '{1'b0, 3,  4'b0000, 32'h0,         32'hAAFF_CCFF, ERR_NONE};
        vecs[4]  = '{1'b0, 58, 4'b0000, 32'h0,         32'h0,         ERR_ADDR};
        vecs[5]  = '{1'b1, 45, 4'b1111, 32'h1234_5678, 32'h0,         ERR_ADDR};
        vecs[6]  = '{1'b0, 45, 4'b0000, 32'h0,         32'h0,         ERR_ADDR};
        vecs[7]  = '{1'b1, 0,  4'b1111, 32'h5555_5555, 32'h0,         ERR_ADDR};
        vecs[8]  = '{1'b1, 1,  4'b1111, 32'h8000_0000, 32'h0,         ERR_ADDR};
        vecs[9]  = '{1'b1, 41, 4'b1111, 32'h0000_0001, 32'h0,         ERR_ADDR};
        vecs[10] = '{1'b1, 3,  4'b1111, 32'h0000_0000, 32'h0,         ERR_ADDR};
        vecs[11] = '{1'b0, 41, 4'b0000, 32'h0,         32'h0000_0001, ERR_ADDR};
        vecs[12] = '{1'b0, 1,  4'b0000, 32'h0,         32'h8000_0000, ERR_ADDR};
        vecs[13] = '{1'b0, 57, 4'b0000, 32'h0,         32'h0,         ERR_ADDR};
        vecs[14] = '{1'b0, 0,  4'b0000, 32'h0,         32'h5555_5555, ERR_ADDR};

        // Reset state
        tick(); tick();
        check("rst_state", accel_state, IDLE);
        check("rst_err", accel_error, ERR_NONE);
        check("rst_done", done, 1'b0);
        check("rst_valid", core_in_valid, 1'b0);
        check("rst_oready", core_out_ready, 1'b0);
        check("rst_olb", output_length_byte, 7'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Host-port vector table
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].we) begin
                mem_en = 1'b1; mem_we = 1'b1; mem_addr = 32'(vecs[v].addr);
                mem_be = vecs[v].be; mem_wdata = vecs[v].wdata;
                tick();
                mem_en = 1'b0; mem_we = 1'b0;
                if (vecs[v].addr < 42) begin
                    for (int b = 0; b < 4; b++) begin
                        if (vecs[v].be[b]) in_model[vecs[v].addr][b*8 +: 8] = vecs[v].wdata[b*8 +: 8];
                    end
                end
            end else begin
                do_read(vecs[v].addr, vecs[v].exp_rd, $sformatf("vec%0d_rdata", v));
            end
            check($sformatf("vec%0d_err", v), accel_error, vecs[v].exp_err);
        end
        tick();
        check("rdata_hold", mem_rdata, 32'h5555_5555);

        // Length errors
        start_job(6'd0);
        check("len0_state", accel_state, IDLE);
        check("len0_err", accel_error, ERR_LEN);
        do_read(58, 32'd0, "len_mid_rdata");
        check("len_mid_err", accel_error, ERR_ADDR);
        start_job(6'd43);
        check("len43_state", accel_state, IDLE);
        check("len43_err", accel_error, ERR_LEN);
        check("len43_valid", core_in_valid, 1'b0);

        // Full-rate job
        push_stream(42);
        core_in_ready = 1'b1;
        start_job(6'd42);
        t0 = cyc;
        check("full_state", accel_state, FEED);
        check("full_valid", core_in_valid, 1'b1);
        check("full_oready", core_out_ready, 1'b0);
        check("full_err_clr", accel_error, ERR_NONE);
        core_in_ready = 1'b1;
        for (int i = 0; i < 100 && accel_state != COLLECT; i++) tick();
        if (accel_state != COLLECT) timeout_fail("full_feed");
        core_in_ready = 1'b0;
        check("full_in_hs", in_hs_cnt, 42);
        check("full_q_empty", exp_in_q.size(), 0);
        check("full_valid_off", core_in_valid, 1'b0);
        send_results(8, 32'hA0);
        check("full_latency", cyc - t0 + 1, 42 + 8 + 1);
        check("full_done", done, 1'b1);
        check("full_state_done", accel_state, DONE);
        check("full_olb", output_length_byte, 7'd32);
        check("full_err", accel_error, ERR_NONE);
        for (int i = 0; i < 8; i++) do_read(42 + i, 32'hA0 + 32'(i), $sformatf("full_res%0d", i));
        check("full_err_after", accel_error, ERR_NONE);

        // Overflow job
        push_stream(2);
        start_job(6'd2);
        check("ovf_done_clr", done, 1'b0);
        check("ovf_olb_clr", output_length_byte, 7'd0);
        core_in_ready = 1'b1;
        wait_collect(1'b0);
        send_results(20, 32'hB0);
        check("ovf_done", done, 1'b1);
        check("ovf_olb", output_length_byte, 7'd64);
        check("ovf_err", accel_error, ERR_OVF);
        for (int i = 0; i < 16; i++) do_read(42 + i, 32'hB0 + 32'(i), $sformatf("ovf_res%0d", i));

        // Busy access during FEED with a stalling core
        push_stream(42);
        core_in_ready = 1'b0;
        start_job(6'd42);
        check("busy_err_clr", accel_error, ERR_NONE);
        start = 1'b1; in_len = 6'd5;
        tick();
        start = 1'b0;
        check("busy_start_state", accel_state, FEED);
        check("busy_start_err", accel_error, ERR_BUSY);
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = 32'd0; mem_be = 4'hF; mem_wdata = 32'hDEAD_BEEF;
        tick();
        mem_en = 1'b0; mem_we = 1'b0;
        check("busy_wr_err", accel_error, ERR_BUSY);
        wait_collect(1'b1);
        check("busy_q_empty", exp_in_q.size(), 0);
        send_results(3, 32'hC0);
        check("busy_done", done, 1'b1);
        check("busy_olb", output_length_byte, 7'd12);
        do_read(0, 32'h5555_5555, "busy_word0");

        // Reset in the middle of FEED
        push_stream(42);
        core_in_ready = 1'b1;
        start_job(6'd42);
        for (int i = 0; i < 100 && in_hs_cnt < 10; i++) tick();
        if (in_hs_cnt != 10) timeout_fail("rst_wait_word10");
        core_in_ready = 1'b0;
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'd0;
        tick();
        mem_en = 1'b0;
        check("mid_busy_err", accel_error, ERR_BUSY);
        rst = 1'b1;
        tick();
        check("mid_state", accel_state, IDLE);
        check("mid_valid", core_in_valid, 1'b0);
        check("mid_oready", core_out_ready, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_err", accel_error, ERR_NONE);
        rst = 1'b0;
        exp_in_q.delete();
        do_read(0, 32'd0, "mid_word0");
        do_read(42, 32'd0, "mid_res0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
